// File: rtl/plic_arbiter.sv
// PLIC central arbiter. It picks the highest-priority enabled pending source above threshold,
// drives irq, and runs the claim/complete handshake with a one-cycle int_end release pulse.
module plic_arbiter #(
  parameter int unsigned NSRC   = 8,
  parameter int unsigned PRIO_W = 3,
  parameter int unsigned ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSRC-1:0]          int_req,
  input  logic [NSRC-1:0]          src_en,
  input  logic [NSRC*PRIO_W-1:0]   src_prio,
  input  logic [PRIO_W-1:0]        threshold,
  input  logic                     claim_req,
  output logic [ID_W-1:0]          claim_id,
  input  logic                     complete_req,
  input  logic [ID_W-1:0]          complete_id,
  output logic [NSRC-1:0]          int_end,
  output logic                     irq
);

  typedef enum logic [1:0] {IDLE, SERVICE, RELEASE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ID_W-1:0]   r_best_id;
  logic [ID_W-1:0]   r_active_id;
  logic [ID_W-1:0]   w_best_id;
  logic [PRIO_W-1:0] r_best_prio;
  logic [PRIO_W-1:0] w_best_prio;
  logic [NSRC-1:0]   w_elig;
  logic [NSRC-1:0]   w_end_onehot;
  logic              w_complete_hit;

  // The claimed source stays masked from SERVICE until the return to IDLE.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_elig[i] = int_req[i] & src_en[i]
                & (src_prio[i*PRIO_W +: PRIO_W] > threshold)
                & ((r_state == IDLE) | (ID_W'(i + 1) != r_active_id));
    end
  end

  // A strict compare keeps the lowest ID on a priority tie.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (w_elig[i] && (src_prio[i*PRIO_W +: PRIO_W] > w_best_prio)) begin
        w_best_id   = ID_W'(i + 1);
        w_best_prio = src_prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

  always_comb begin
    w_end_onehot = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_end_onehot[i] = (ID_W'(i + 1) == r_active_id);
    end
  end

  assign w_complete_hit = complete_req && (complete_id == r_active_id);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (claim_req && (r_best_prio != '0)) w_state_next = SERVICE;
      SERVICE: if (w_complete_hit) w_state_next = RELEASE;
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_best_id   <= '0;
      r_best_prio <= '0;
      r_active_id <= '0;
      claim_id    <= '0;
      int_end     <= '0;
      irq         <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_best_id   <= w_best_id;
      r_best_prio <= w_best_prio;
      irq         <= (w_state_next == IDLE) && (w_best_id != '0);
      int_end     <= '0;
      case (r_state)
        IDLE: begin
          // A nonzero best priority is equivalent to a nonzero best ID.
          if (claim_req) begin
            if (r_best_prio != '0) begin
              claim_id    <= r_best_id;
              r_active_id <= r_best_id;
            end else begin
              claim_id <= '0;
            end
          end
        end
        SERVICE: begin
          if (claim_req) claim_id <= '0;
          if (w_complete_hit) int_end <= w_end_onehot;
        end
        RELEASE: begin
          if (claim_req) claim_id <= '0;
          r_active_id <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
